// File: rtl/ps2_capture_buffer.sv
// Timestamped capture FIFO for PS/2 received bytes: folds E0/F0 prefixes into
// per-entry flags, first-word-fall-through read, drop-new or overwrite-oldest when full.
module ps2_capture_buffer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int TS_W         = 16,
  parameter int MODE         = 0,
  parameter int MERGE_PREFIX = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        received_data,
  input  logic                     received_data_en,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [TS_W+DATA_W+1:0]   rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [ADDR_W:0]          count,
  output logic                     overflow
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = TS_W + DATA_W + 2;
  localparam logic [DATA_W-1:0] EXT_BYTE = DATA_W'('hE0);
  localparam logic [DATA_W-1:0] BRK_BYTE = DATA_W'('hF0);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [TS_W-1:0]   ts_ctr;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              ext_pend, brk_pend;

  logic              is_ext, is_brk, accept, pop, do_write, adv_rd, ovf_hit;
  logic [ADDR_W:0]   count_nxt;
  logic [ENTRY_W-1:0] wr_entry;

  assign empty    = (count_q == '0);
  assign full     = (count_q == COUNT_MAX);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    is_ext    = 1'b0;
    is_brk    = 1'b0;
    accept    = 1'b0;
    pop       = 1'b0;
    do_write  = 1'b0;
    adv_rd    = 1'b0;
    ovf_hit   = 1'b0;
    count_nxt = count_q;
    wr_entry  = {ts_ctr, ext_pend, brk_pend, received_data};

    if (MERGE_PREFIX != 0) begin
      is_ext = (received_data == EXT_BYTE);
      is_brk = (received_data == BRK_BYTE);
    end
    accept = received_data_en && !is_ext && !is_brk;
    pop    = rd_en && !empty;

    // A same-cycle pop frees the slot, so a full buffer only overflows without one.
    if (accept) begin
      if (!full || pop) begin
        do_write = 1'b1;
      end else begin
        ovf_hit = 1'b1;
        if (MODE != 0) begin
          do_write = 1'b1;
          adv_rd   = 1'b1;
        end
      end
    end
    if (pop) adv_rd = 1'b1;

    if (do_write && !pop && !full) count_nxt = count_q + (ADDR_W+1)'(1);
    else if (pop && !do_write)     count_nxt = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ts_ctr <= '0;
    end else begin
      ts_ctr <= ts_ctr + TS_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + ADDR_W'(1);
      count_q <= count_nxt;
      if (ovf_hit) overflow_q <= 1'b1;
      if (accept) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (received_data_en) begin
        if (is_ext) ext_pend <= 1'b1;
        if (is_brk) brk_pend <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; rd_data is meaningless while empty.
  always_ff @(posedge CLOCK_50) begin
    if (do_write && !clear) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_ps2_capture_buffer.sv
// Drives a drop-new and an overwrite-oldest buffer (depth 4) with the same stimulus
// and scoreboards each against its own queue of expected entries.
module tb_ps2_capture_buffer;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TW = 16;
  localparam int EW = TW + DW + 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] received_data = '0;
  logic          received_data_en = 1'b0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;

  logic [EW-1:0] rd_data0, rd_data1;
  logic          empty0, empty1, full0, full1, overflow0, overflow1;
  logic [AW:0]   count0, count1;

  ps2_capture_buffer #(.DATA_W(DW), .ADDR_W(AW), .TS_W(TW), .MODE(0), .MERGE_PREFIX(1)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data),
    .received_data_en(received_data_en), .clear(clear), .rd_en(rd_en),
    .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0), .overflow(overflow0));

  ps2_capture_buffer #(.DATA_W(DW), .ADDR_W(AW), .TS_W(TW), .MODE(1), .MERGE_PREFIX(1)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data),
    .received_data_en(received_data_en), .clear(clear), .rd_en(rd_en),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1), .overflow(overflow1));

  always #10 CLOCK_50 = ~CLOCK_50;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic          ovf0_m = 1'b0, ovf1_m = 1'b0;
  logic          ext_m = 1'b0, brk_m = 1'b0;
  logic [TW-1:0] ts_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count0", 32'(count0), 32'(q0.size()));
    chk("count1", 32'(count1), 32'(q1.size()));
    chk("empty0", 32'(empty0), 32'(q0.size() == 0));
    chk("empty1", 32'(empty1), 32'(q1.size() == 0));
    chk("full0", 32'(full0), 32'(q0.size() == 4));
    chk("full1", 32'(full1), 32'(q1.size() == 4));
    chk("ovf0", 32'(overflow0), 32'(ovf0_m));
    chk("ovf1", 32'(overflow1), 32'(ovf1_m));
    if (q0.size() > 0) chk("head0", 32'(rd_data0), 32'(q0[0]));
    if (q1.size() > 0) chk("head1", 32'(rd_data1), 32'(q1[0]));
  endtask

  // One clock cycle: entered and left in the low phase of CLOCK_50.
  task automatic cyc(input logic en, input logic [DW-1:0] d, input logic rd, input logic clr);
    logic          pref, acc;
    logic [EW-1:0] ent;
    received_data_en = en;
    received_data    = d;
    rd_en            = rd;
    clear            = clr;
    #1;
    pref = (d == 8'hE0) || (d == 8'hF0);
    acc  = en && !pref;
    ent  = {ts_m, ext_m, brk_m, d};
    if (clr) begin
      q0.delete(); q1.delete();
      ovf0_m = 1'b0; ovf1_m = 1'b0; ext_m = 1'b0; brk_m = 1'b0;
    end else begin
      if (rd && q0.size() > 0) chk("pop0", 32'(rd_data0), 32'(q0.pop_front()));
      if (rd && q1.size() > 0) chk("pop1", 32'(rd_data1), 32'(q1.pop_front()));
      if (acc) begin
        if (q0.size() < 4) q0.push_back(ent);
        else ovf0_m = 1'b1;
        if (q1.size() < 4) q1.push_back(ent);
        else begin
          void'(q1.pop_front());
          q1.push_back(ent);
          ovf1_m = 1'b1;
        end
        ext_m = 1'b0;
        brk_m = 1'b0;
      end else if (en) begin
        if (d == 8'hE0) ext_m = 1'b1;
        if (d == 8'hF0) brk_m = 1'b1;
      end
    end
    @(posedge CLOCK_50);
    ts_m = ts_m + 16'd1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    rd_en            = 1'b0;
    clear            = 1'b0;
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge CLOCK_50);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    #2 reset = 1'b1;
    ts_m = '0;
    check_state();

    // Basic write and pop: 1C captured at ts=10.
    idle(10);
    cyc(1'b1, 8'h1C, 1'b0, 1'b0);
    chk("basic_entry", 32'(rd_data0), 32'({16'd10, 2'b00, 8'h1C}));
    chk("basic_count", 32'(count0), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("basic_empty", 32'(empty0), 32'd1);

    // Prefix folding.
    cyc(1'b1, 8'hE0, 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    chk("prefix_hidden", 32'(count0), 32'd0);
    cyc(1'b1, 8'h75, 1'b0, 1'b0);
    chk("prefix_flags", 32'(rd_data0[DW+1:DW]), 32'd3);
    cyc(1'b1, 8'h74, 1'b1, 1'b0);
    chk("plain_flags", 32'(rd_data0[DW+1:DW]), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);   // pop on empty is ignored

    // Fill past capacity: drop-new keeps 01..04, overwrite keeps 03..06.
    for (int b = 1; b <= 6; b++) cyc(1'b1, 8'(b), 1'b0, 1'b0);
    chk("full_ovf0", 32'(overflow0), 32'd1);
    chk("full_ovf1", 32'(overflow1), 32'd1);
    chk("drop_head", 32'(rd_data0[DW-1:0]), 32'h01);
    chk("ovw_head", 32'(rd_data1[DW-1:0]), 32'h03);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous pop and write when full: no overflow.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int b = 1; b <= 4; b++) cyc(1'b1, 8'(b), 1'b0, 1'b0);
    cyc(1'b1, 8'h09, 1'b1, 1'b0);
    chk("popw_count", 32'(count0), 32'd4);
    chk("popw_ovf", 32'(overflow0), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h21, 1'b1, 1'b0);   // write with pop on empty: write only

    // Clear during a strobe, with a pending E0 and a set overflow.
    for (int b = 1; b <= 5; b++) cyc(1'b1, 8'(b + 16), 1'b0, 1'b0);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b1);
    chk("clr_count", 32'(count1), 32'd0);
    chk("clr_ovf", 32'(overflow1), 32'd0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    chk("clr_pend", 32'(rd_data0[DW+1:DW]), 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [DW-1:0] d;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 8'hDF));
      cyc(1'($urandom_range(0, 1)), d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0));
    end

    // Mid-stream asynchronous reset.
    for (int b = 1; b <= 5; b++) cyc(1'b1, 8'(b + 32), 1'b0, 1'b0);
    cyc(1'b1, 8'hF0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("arst_count0", 32'(count0), 32'd0);
    chk("arst_count1", 32'(count1), 32'd0);
    chk("arst_empty", 32'(empty1), 32'd1);
    chk("arst_full", 32'(full1), 32'd0);
    chk("arst_ovf0", 32'(overflow0), 32'd0);
    chk("arst_ovf1", 32'(overflow1), 32'd0);
    q0.delete(); q1.delete();
    ovf0_m = 1'b0; ovf1_m = 1'b0; ext_m = 1'b0; brk_m = 1'b0;
    ts_m = '0;
    #2 reset = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("arst_first", 32'(rd_data0), 32'({16'd0, 2'b00, 8'h5A}));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
